// File: rtl/bnn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bnn_ctrl_pkg: shared states, tag type and defaults for the BNN layer scheduler.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package bnn_ctrl_pkg;

   localparam int ROWS_DEF     = 28;
   localparam int COLS_DEF     = 32;
   localparam int PIPE_LAT_DEF = 6;
   localparam int ADDR_W_DEF   = 5;

   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] row;
      logic [ADDR_W_DEF-1:0] col;
   } tag_t;

endpackage

`default_nettype wire

// File: rtl/bnn_layer_scheduler_if.sv
// -----------------------------------------------------------------------------
// bnn_layer_scheduler_if: handshake, stall and memory-strobe bundle of the scheduler.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface bnn_layer_scheduler_if #(
   parameter int ADDR_W = 5
);
   logic              start;
   logic              stall;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] graph_mem_rowaddr;
   logic [ADDR_W-1:0] graph_mem_coladdr;
   logic              input_mem_en;
   logic              input_mem_RW;
   logic [ADDR_W-1:0] out_mem_rowaddr;
   logic [ADDR_W-1:0] out_mem_coladdr;
   logic              output_mem_en;
   logic              output_mem_RW;
   logic              buffer_en;

   modport master (
      output start, stall,
      input  busy, done, graph_mem_rowaddr, graph_mem_coladdr, input_mem_en,
             input_mem_RW, out_mem_rowaddr, out_mem_coladdr, output_mem_en,
             output_mem_RW, buffer_en
   );

   modport slave (
      input  start, stall,
      output busy, done, graph_mem_rowaddr, graph_mem_coladdr, input_mem_en,
             input_mem_RW, out_mem_rowaddr, out_mem_coladdr, output_mem_en,
             output_mem_RW, buffer_en
   );
endinterface

`default_nettype wire

// File: rtl/bnn_tag_pipe.sv
// -----------------------------------------------------------------------------
// bnn_tag_pipe: PIPE_LAT-deep tag shift register mirroring datapath latency.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module bnn_tag_pipe
   import bnn_ctrl_pkg::*;
#(
   parameter int  PIPE_LAT = PIPE_LAT_DEF,
   parameter type TAG_T    = tag_t
) (
   input  wire  clk,
   input  wire  rst,
   input  logic adv_i,
   input  TAG_T tag_i,
   output TAG_T last_o,
   output logic any_valid_o
);

   TAG_T stage_q [PIPE_LAT];
   TAG_T stage_d [PIPE_LAT];

   // any_valid_o looks at the post-update contents so a drain can end on the final write
   always_comb begin
      stage_d     = stage_q;
      any_valid_o = 1'b0;
      if (adv_i) begin
         stage_d[0] = tag_i;
         for (int i = 1; i < PIPE_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
      for (int i = 0; i < PIPE_LAT; i++) begin
         any_valid_o = any_valid_o | stage_d[i].valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign last_o = stage_q[PIPE_LAT-1];

endmodule

`default_nettype wire

// File: rtl/bnn_layer_scheduler.sv
// -----------------------------------------------------------------------------
// bnn_layer_scheduler: raster frame sequencer with tagged write-back and global stall.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module bnn_layer_scheduler
   import bnn_ctrl_pkg::*;
#(
   parameter int ROWS     = ROWS_DEF,
   parameter int COLS     = COLS_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input wire clk,
   input wire rst,
   bnn_layer_scheduler_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
   } sched_tag_t;

   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic              issue;
   logic              last_col;
   logic              last_issue;
   logic              pipe_busy;
   sched_tag_t        tag_in;
   sched_tag_t        tag_last;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      issue      = (state_q == ST_RUN) && !bus.stall;
      last_col   = (col_q == COL_LAST);
      last_issue = issue && last_col && (row_q == ROW_LAST);
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_RUN;
         ST_RUN: begin
            if (issue) begin
               if (last_col) begin
                  col_d = '0;
                  // wrap to (0,0) after the final read so the next frame starts clean
                  row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
            if (last_issue) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (!pipe_busy) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign tag_in = '{valid: issue, row: row_q, col: col_q};

   bnn_tag_pipe #(
      .PIPE_LAT (PIPE_LAT),
      .TAG_T    (sched_tag_t)
   ) u_tag_pipe (
      .clk         (clk),
      .rst         (rst),
      .adv_i       (!bus.stall),
      .tag_i       (tag_in),
      .last_o      (tag_last),
      .any_valid_o (pipe_busy)
   );

   assign bus.busy              = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bus.done              = (state_q == ST_DONE);
   assign bus.input_mem_en      = issue;
   assign bus.input_mem_RW      = MEM_READ;
   assign bus.graph_mem_rowaddr = row_q;
   assign bus.graph_mem_coladdr = col_q;
   assign bus.output_mem_en     = tag_last.valid && !bus.stall;
   assign bus.output_mem_RW     = MEM_WRITE;
   assign bus.out_mem_rowaddr   = tag_last.valid ? tag_last.row : '0;
   assign bus.out_mem_coladdr   = tag_last.valid ? tag_last.col : '0;
   assign bus.buffer_en         = bus.busy && !bus.stall;

endmodule

`default_nettype wire

// File: tb/tb_bnn_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bnn_layer_scheduler: directed bench for default (28x32, lat 6) and small (2x4, lat 3) schedulers.  Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_bnn_layer_scheduler;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   bnn_layer_scheduler_if #(.ADDR_W(5)) bus_a ();
   bnn_layer_scheduler_if #(.ADDR_W(5)) bus_b ();

   bnn_layer_scheduler #(.ROWS(28), .COLS(32), .PIPE_LAT(6), .ADDR_W(5)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   bnn_layer_scheduler #(.ROWS(2), .COLS(4), .PIPE_LAT(3), .ADDR_W(5)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   // Invariants sampled mid-cycle on every cycle of every scenario
   always @(negedge clk) begin
      checks++;
      if (bus_a.input_mem_RW !== 1'b1 || bus_b.input_mem_RW !== 1'b1) begin
         errors++;
         $display("FAIL static_input_RW a=%b b=%b expected 1", bus_a.input_mem_RW, bus_b.input_mem_RW);
      end
      checks++;
      if (bus_a.output_mem_RW !== 1'b0 || bus_b.output_mem_RW !== 1'b0) begin
         errors++;
         $display("FAIL static_output_RW a=%b b=%b expected 0", bus_a.output_mem_RW, bus_b.output_mem_RW);
      end
      checks++;
      if (bus_a.buffer_en !== (bus_a.busy & ~bus_a.stall)) begin
         errors++;
         $display("FAIL static_buffer_en_a got=%b expected=%b", bus_a.buffer_en, bus_a.busy & ~bus_a.stall);
      end
      checks++;
      if (bus_b.buffer_en !== (bus_b.busy & ~bus_b.stall)) begin
         errors++;
         $display("FAIL static_buffer_en_b got=%b expected=%b", bus_b.buffer_en, bus_b.busy & ~bus_b.stall);
      end
   end

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.start = 1'b1; bus_b.start = 1'b1;
      bus_a.stall = 1'b0; bus_b.stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b0; rst_b = 1'b0;
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      #2;
      checks++;
      if ({bus_a.busy, bus_a.done, bus_a.input_mem_en, bus_a.output_mem_en, bus_a.buffer_en} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl_a got=%b expected=00000",
                  {bus_a.busy, bus_a.done, bus_a.input_mem_en, bus_a.output_mem_en, bus_a.buffer_en});
      end
      checks++;
      if ({bus_a.graph_mem_rowaddr, bus_a.graph_mem_coladdr, bus_a.out_mem_rowaddr, bus_a.out_mem_coladdr} !== 20'b0) begin
         errors++;
         $display("FAIL reset_addr_a got=%h expected=0",
                  {bus_a.graph_mem_rowaddr, bus_a.graph_mem_coladdr, bus_a.out_mem_rowaddr, bus_a.out_mem_coladdr});
      end
      checks++;
      if ({bus_b.busy, bus_b.done, bus_b.input_mem_en, bus_b.output_mem_en, bus_b.buffer_en} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl_b got=%b expected=00000",
                  {bus_b.busy, bus_b.done, bus_b.input_mem_en, bus_b.output_mem_en, bus_b.buffer_en});
      end
      checks++;
      if ({bus_b.graph_mem_rowaddr, bus_b.graph_mem_coladdr, bus_b.out_mem_rowaddr, bus_b.out_mem_coladdr} !== 20'b0) begin
         errors++;
         $display("FAIL reset_addr_b got=%h expected=0",
                  {bus_b.graph_mem_rowaddr, bus_b.graph_mem_coladdr, bus_b.out_mem_rowaddr, bus_b.out_mem_coladdr});
      end
      // A stall in IDLE must not wake anything up
      @(posedge clk); #1; bus_b.stall = 1'b1; #2;
      checks++;
      if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0 || bus_b.input_mem_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_hold busy_a=%b busy_b=%b en_b=%b expected 0", bus_a.busy, bus_b.busy, bus_b.input_mem_en);
      end
      @(posedge clk); #1; bus_b.stall = 1'b0;
   endtask

   // 2x4 frame, lat 3, stall in cycles 3-5
   task automatic test_stall();
      logic [31:0] stall_m = 32'h0000_0038;
      logic [31:0] rd_m    = 32'h0000_0FC6;
      logic [31:0] wr_m    = 32'h0000_7F80;
      logic [31:0] busy_m  = 32'h0000_7FFE;
      int          rd_idx  = 0;
      int          wr_idx  = 0;
      for (int cyc = 0; cyc < 18; cyc++) begin
         @(posedge clk); #1;
         bus_b.start = (cyc == 0);
         bus_b.stall = stall_m[cyc];
         #2;
         checks++;
         if (bus_b.input_mem_en !== rd_m[cyc]) begin
            errors++;
            $display("FAIL stall_rd_en cyc=%0d got=%b expected=%b", cyc, bus_b.input_mem_en, rd_m[cyc]);
         end
         checks++;
         if (bus_b.output_mem_en !== wr_m[cyc]) begin
            errors++;
            $display("FAIL stall_wr_en cyc=%0d got=%b expected=%b", cyc, bus_b.output_mem_en, wr_m[cyc]);
         end
         checks++;
         if (bus_b.busy !== busy_m[cyc] || bus_b.done !== (cyc == 15)) begin
            errors++;
            $display("FAIL stall_busy_done cyc=%0d got=%b%b expected=%b%b", cyc, bus_b.busy, bus_b.done,
                     busy_m[cyc], (cyc == 15));
         end
         if (rd_m[cyc]) begin
            checks++;
            if (bus_b.graph_mem_rowaddr !== 5'(rd_idx / 4) || bus_b.graph_mem_coladdr !== 5'(rd_idx % 4)) begin
               errors++;
               $display("FAIL stall_rd_addr cyc=%0d got=(%0d,%0d) expected=(%0d,%0d)", cyc,
                        bus_b.graph_mem_rowaddr, bus_b.graph_mem_coladdr, rd_idx / 4, rd_idx % 4);
            end
            rd_idx++;
         end
         if (wr_m[cyc]) begin
            checks++;
            if (bus_b.out_mem_rowaddr !== 5'(wr_idx / 4) || bus_b.out_mem_coladdr !== 5'(wr_idx % 4)) begin
               errors++;
               $display("FAIL stall_wr_addr cyc=%0d got=(%0d,%0d) expected=(%0d,%0d)", cyc,
                        bus_b.out_mem_rowaddr, bus_b.out_mem_coladdr, wr_idx / 4, wr_idx % 4);
            end
            wr_idx++;
         end
         if (stall_m[cyc]) begin
            checks++;
            if (bus_b.graph_mem_rowaddr !== 5'd0 || bus_b.graph_mem_coladdr !== 5'd2) begin
               errors++;
               $display("FAIL stall_hold_addr cyc=%0d got=(%0d,%0d) expected=(0,2)", cyc,
                        bus_b.graph_mem_rowaddr, bus_b.graph_mem_coladdr);
            end
         end
         if (cyc == 15) begin
            checks++;
            if (bus_b.out_mem_rowaddr !== 5'd0 || bus_b.out_mem_coladdr !== 5'd0) begin
               errors++;
               $display("FAIL stall_out_addr_idle got=(%0d,%0d) expected=(0,0)", bus_b.out_mem_rowaddr, bus_b.out_mem_coladdr);
            end
         end
      end
      bus_b.stall = 1'b0;
   endtask

   // 2x4 frame, lat 3, stall only in the last-issue cycle 8
   task automatic test_last_issue_stall();
      logic [31:0] stall_m = 32'h0000_0100;
      logic [31:0] rd_m    = 32'h0000_02FE;
      logic [31:0] wr_m    = 32'h0000_1EF0;
      logic [31:0] busy_m  = 32'h0000_1FFE;
      int          rd_idx  = 0;
      int          wr_idx  = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(posedge clk); #1;
         bus_b.start = (cyc == 0);
         bus_b.stall = stall_m[cyc];
         #2;
         checks++;
         if (bus_b.input_mem_en !== rd_m[cyc]) begin
            errors++;
            $display("FAIL last_rd_en cyc=%0d got=%b expected=%b", cyc, bus_b.input_mem_en, rd_m[cyc]);
         end
         checks++;
         if (bus_b.output_mem_en !== wr_m[cyc]) begin
            errors++;
            $display("FAIL last_wr_en cyc=%0d got=%b expected=%b", cyc, bus_b.output_mem_en, wr_m[cyc]);
         end
         checks++;
         if (bus_b.busy !== busy_m[cyc] || bus_b.done !== (cyc == 13)) begin
            errors++;
            $display("FAIL last_busy_done cyc=%0d got=%b%b expected=%b%b", cyc, bus_b.busy, bus_b.done,
                     busy_m[cyc], (cyc == 13));
         end
         if (rd_m[cyc]) begin
            checks++;
            if (bus_b.graph_mem_rowaddr !== 5'(rd_idx / 4) || bus_b.graph_mem_coladdr !== 5'(rd_idx % 4)) begin
               errors++;
               $display("FAIL last_rd_addr cyc=%0d got=(%0d,%0d) expected=(%0d,%0d)", cyc,
                        bus_b.graph_mem_rowaddr, bus_b.graph_mem_coladdr, rd_idx / 4, rd_idx % 4);
            end
            rd_idx++;
         end
         if (wr_m[cyc]) begin
            checks++;
            if (bus_b.out_mem_rowaddr !== 5'(wr_idx / 4) || bus_b.out_mem_coladdr !== 5'(wr_idx % 4)) begin
               errors++;
               $display("FAIL last_wr_addr cyc=%0d got=(%0d,%0d) expected=(%0d,%0d)", cyc,
                        bus_b.out_mem_rowaddr, bus_b.out_mem_coladdr, wr_idx / 4, wr_idx % 4);
            end
            wr_idx++;
         end
         if (cyc == 8) begin
            checks++;
            if (bus_b.graph_mem_rowaddr !== 5'd1 || bus_b.graph_mem_coladdr !== 5'd3) begin
               errors++;
               $display("FAIL last_hold_addr got=(%0d,%0d) expected=(1,3)", bus_b.graph_mem_rowaddr, bus_b.graph_mem_coladdr);
            end
         end
      end
      bus_b.stall = 1'b0;
   endtask

   // Default frame with ignored re-starts at 10 (RUN) and 903 (DONE), restart at 904 (IDLE)
   task automatic test_default_frame();
      int   wr_cnt = 0;
      int   idx;
      logic exp_rd, exp_wr, exp_busy;
      @(posedge clk); #1; bus_a.start = 1'b1; #2;
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.input_mem_en !== 1'b0) begin
         errors++;
         $display("FAIL frame_cycle0 busy=%b en=%b expected 0 0", bus_a.busy, bus_a.input_mem_en);
      end
      for (int cyc = 1; cyc <= 904; cyc++) begin
         @(posedge clk); #1;
         bus_a.start = (cyc == 10) || (cyc == 903) || (cyc == 904);
         #2;
         exp_rd   = (cyc >= 1) && (cyc <= 896);
         exp_wr   = (cyc >= 7) && (cyc <= 902);
         exp_busy = (cyc <= 902);
         checks++;
         if (bus_a.input_mem_en !== exp_rd) begin
            errors++;
            $display("FAIL frame_rd_en cyc=%0d got=%b expected=%b", cyc, bus_a.input_mem_en, exp_rd);
         end
         checks++;
         if (bus_a.output_mem_en !== exp_wr) begin
            errors++;
            $display("FAIL frame_wr_en cyc=%0d got=%b expected=%b", cyc, bus_a.output_mem_en, exp_wr);
         end
         checks++;
         if (bus_a.busy !== exp_busy || bus_a.done !== (cyc == 903)) begin
            errors++;
            $display("FAIL frame_busy_done cyc=%0d got=%b%b expected=%b%b", cyc, bus_a.busy, bus_a.done,
                     exp_busy, (cyc == 903));
         end
         if (exp_rd) begin
            idx = cyc - 1;
            checks++;
            if (bus_a.graph_mem_rowaddr !== 5'(idx / 32) || bus_a.graph_mem_coladdr !== 5'(idx % 32)) begin
               errors++;
               $display("FAIL frame_rd_addr cyc=%0d got=(%0d,%0d) expected=(%0d,%0d)", cyc,
                        bus_a.graph_mem_rowaddr, bus_a.graph_mem_coladdr, idx / 32, idx % 32);
            end
         end
         if (exp_wr) begin
            idx = cyc - 7;
            checks++;
            if (bus_a.out_mem_rowaddr !== 5'(idx / 32) || bus_a.out_mem_coladdr !== 5'(idx % 32)) begin
               errors++;
               $display("FAIL frame_wr_addr cyc=%0d got=(%0d,%0d) expected=(%0d,%0d)", cyc,
                        bus_a.out_mem_rowaddr, bus_a.out_mem_coladdr, idx / 32, idx % 32);
            end
         end
         if (cyc == 3 || cyc == 904) begin
            checks++;
            if (bus_a.out_mem_rowaddr !== 5'd0 || bus_a.out_mem_coladdr !== 5'd0) begin
               errors++;
               $display("FAIL frame_out_addr_zero cyc=%0d got=(%0d,%0d) expected=(0,0)", cyc,
                        bus_a.out_mem_rowaddr, bus_a.out_mem_coladdr);
            end
         end
         if (bus_a.output_mem_en === 1'b1) wr_cnt++;
      end
      checks++;
      if (wr_cnt !== 896) begin
         errors++;
         $display("FAIL frame_write_count got=%0d expected=896", wr_cnt);
      end
      // Frame cycle 1 of the restarted frame
      @(posedge clk); #1; bus_a.start = 1'b0; #2;
      checks++;
      if (bus_a.busy !== 1'b1 || bus_a.input_mem_en !== 1'b1 ||
          bus_a.graph_mem_rowaddr !== 5'd0 || bus_a.graph_mem_coladdr !== 5'd0) begin
         errors++;
         $display("FAIL restart_first_read busy=%b en=%b addr=(%0d,%0d) expected 1 1 (0,0)", bus_a.busy,
                  bus_a.input_mem_en, bus_a.graph_mem_rowaddr, bus_a.graph_mem_coladdr);
      end
   endtask

   // Continues the restarted frame; reset in its cycle 400
   task automatic test_midframe_reset();
      for (int f = 2; f < 400; f++) begin
         @(posedge clk);
      end
      @(posedge clk); #1; rst_a = 1'b1;
      @(posedge clk); #1; rst_a = 1'b0; #2;
      checks++;
      if ({bus_a.busy, bus_a.done, bus_a.input_mem_en, bus_a.output_mem_en, bus_a.buffer_en} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_ctrl got=%b expected=00000",
                  {bus_a.busy, bus_a.done, bus_a.input_mem_en, bus_a.output_mem_en, bus_a.buffer_en});
      end
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #3;
         checks++;
         if (bus_a.output_mem_en !== 1'b0 || bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet k=%0d wr=%b done=%b busy=%b expected 0 0 0", k,
                     bus_a.output_mem_en, bus_a.done, bus_a.busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stall();
      test_last_issue_stall();
      test_default_frame();
      test_midframe_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
